// File: rtl/fifo_mem_ctrl.sv
// FIFO controller for an external dual-port memory: it keeps the pointers and
// occupancy, drives the memory write/read ports and returns read data through a two-stage pipeline.
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                  Clock,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oDataIn,
    output logic [ADDR_WIDTH-1:0] oReadAddress0,
    input  logic [DATA_WIDTH-1:0] iDataOut0,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH:0]   DEPTH    = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   AF_LEVEL = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0]   AE_LEVEL = (ADDR_WIDTH+1)'(ALMOST_EMPTY);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

    // Each bit marks one occupied stage, so ADDR and CAPTURE overlap when pops run back to back.
    typedef enum logic [1:0] {
        RD_IDLE         = 2'b00,
        RD_CAPTURE      = 2'b01,
        RD_ADDR         = 2'b10,
        RD_ADDR_CAPTURE = 2'b11
    } rd_state_t;

    rd_state_t             rd_state_reg, rd_state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg, raddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg, rdata_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  we_reg, valid_reg, ovf_reg, unf_reg;
    logic                  push_ok, pop_ok, capture_en;

    assign full         = (count_reg == DEPTH);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_LEVEL);
    assign almost_empty = (count_reg <= AE_LEVEL);
    assign count        = count_reg;

    // A pop frees a slot in the same cycle, so a push against a full FIFO is still taken.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign oWriteEnable  = we_reg;
    assign oWriteAddress = waddr_reg;
    assign oDataIn       = wdata_reg;
    assign oReadAddress0 = raddr_reg;
    assign pop_data      = rdata_reg;
    assign pop_valid     = valid_reg;
    assign overflow      = ovf_reg;
    assign underflow     = unf_reg;

    always_ff @(posedge Clock or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            waddr_reg  <= '0;
            raddr_reg  <= '0;
            wdata_reg  <= '0;
            count_reg  <= '0;
            we_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            we_reg <= push_ok;
            if (push_ok) begin
                waddr_reg  <= wr_ptr_reg;
                wdata_reg  <= push_data;
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                raddr_reg  <= rd_ptr_reg;
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - CNT_ONE;
            end
            if (push && !push_ok) begin
                ovf_reg <= 1'b1;
            end
            if (pop && !pop_ok) begin
                unf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge reset_L) begin
        if (!reset_L) begin
            rd_state_reg <= RD_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    always_comb begin
        rd_state_next = RD_IDLE;
        case (rd_state_reg)
            RD_IDLE, RD_CAPTURE:     rd_state_next = pop_ok ? RD_ADDR : RD_IDLE;
            RD_ADDR, RD_ADDR_CAPTURE: rd_state_next = pop_ok ? RD_ADDR_CAPTURE : RD_CAPTURE;
            default:                 rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        capture_en = 1'b0;
        if (rd_state_reg == RD_CAPTURE || rd_state_reg == RD_ADDR_CAPTURE) begin
            capture_en = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge reset_L) begin
        if (!reset_L) begin
            rdata_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= capture_en;
            if (capture_en) begin
                rdata_reg <= iDataOut0;
            end
        end
    end
endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
- FIFO controller that drives the write port and read port of dual_port_memory. The storage array stays in the external memory.
- Turns push/pop requests into iWriteEnable, iWriteAddress, iDataIn and iReadAddress0 pulses.
- Returns read data with a valid strobe and tracks occupancy, full/empty, thresholds and errors.
- Acts as the control end for the memory's write/read interface; it replaces the free-running testbench stimulus.

Parameters:
- DATA_WIDTH, 6, word width; must match the memory.
- ADDR_WIDTH, 3, pointer width; FIFO depth = 2**ADDR_WIDTH (8).
- ALMOST_FULL, 6, almost_full asserts when count >= this value.
- ALMOST_EMPTY, 2, almost_empty asserts when count <= this value.

Ports:
- Clock  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- push  in  1  write request.
- push_data  in  DATA_WIDTH  word to write.
- pop  in  1  read request.
- pop_data  out  DATA_WIDTH  word read, valid when pop_valid=1.
- pop_valid  out  1  one-cycle strobe marking pop_data.
- oWriteEnable  out  1  to memory iWriteEnable.
- oWriteAddress  out  ADDR_WIDTH  to memory iWriteAddress.
- oDataIn  out  DATA_WIDTH  to memory iDataIn.
- oReadAddress0  out  ADDR_WIDTH  to memory iReadAddress0.
- iDataOut0  in  DATA_WIDTH  from memory oDataOut0.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.

Behaviour:
- Reset (reset_L=0, async):
  - wr_ptr, rd_ptr and count = 0.
  - empty=1, almost_empty=1; full=0, almost_full=0.
  - oWriteEnable=0, pop_valid=0, pop_data=0, overflow=0, underflow=0.
  - oWriteAddress, oReadAddress0 and oDataIn = 0.
  - Release is synchronous to the next rising edge.
- Memory contract (decided):
  - Memory writes on the rising edge when iWriteEnable=1.
  - Memory read is registered: oDataOut0 reflects iReadAddress0 one cycle after the address is presented.
- Push accepted when push=1 and (full=0, or pop accepted in the same cycle):
  - Next cycle: oWriteEnable=1, oWriteAddress=wr_ptr, oDataIn=push_data (all registered).
  - wr_ptr increments modulo DEPTH and wraps 7->0.
- Pop accepted when pop=1 and empty=0:
  - Registered oReadAddress0 = rd_ptr; rd_ptr increments modulo DEPTH.
  - Read pipeline states: IDLE -> ADDR (address driven) -> CAPTURE (memory data valid).
  - pop_data and pop_valid are registered from iDataOut0 in CAPTURE.
  - Total latency: pop accepted at edge N, pop_valid=1 during the cycle after edge N+2.
  - Back-to-back pops pipeline at one per cycle.
- Occupancy:
  - count +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither.
  - Flags are combinational from count: full=(count==DEPTH), empty=(count==0).
- Full with push and pop together: both accepted, count stays DEPTH, no overflow.
- Empty with push and pop together: push accepted, pop rejected, underflow set, count becomes 1.
- Read-during-write hazard:
  - A pop cannot target the word written in the same cycle, because count only reflects the push after its write edge.
  - A word becomes poppable the cycle after oWriteEnable has been high.
- Error flags:
  - Push while full without a pop: word dropped, no write, overflow=1.
  - Pop while empty: no read pulse, underflow=1.
  - Both flags clear only on reset.
- Reset asserted mid-operation:
  - In-flight reads are discarded; pop_valid must not assert after reset release for pops issued before reset.
  - oWriteEnable drops immediately (async).

Test Plan:
- Reset, then push 0x01..0x08 on 8 consecutive cycles:
  - oWriteAddress walks 0..7.
  - count=8, full=1, almost_full=1 from count=6.
  - A ninth push of 0x3F sets overflow=1 and produces no oWriteEnable pulse.
- From full, pop 8 consecutive cycles:
  - pop_valid asserts 2 cycles after the first pop.
  - pop_data sequence is 0x01..0x08; empty=1 at the end.
  - An extra pop sets underflow=1 with no read address change.
- Wrap-around: push 5, pop 5, then push 0x2A,0x15,0x3C:
  - Writes land at addresses 5,6,7.
  - Next push 0x07 lands at address 0.
  - Pops return 0x2A,0x15,0x3C,0x07 in order.
- Simultaneous push and pop:
  - At count=8: count stays 8, no overflow, written data read back in order.
  - At count=0: count becomes 1, underflow=1, no pop_valid.
- Reset mid-operation: issue pop at count=3, then drop reset_L one cycle later:
  - All outputs return to reset values immediately.
  - No pop_valid appears after reset release.
  - Subsequent push 0x11 then pop returns 0x11.
